// File: rtl/btn_pkg.sv
// Shared constants for the button event path: button index map and default sizing.
package btn_pkg;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;

   localparam int NUM_BTN_DEF = 4;
   localparam int DEPTH_DEF   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with explicit occupancy count.
module sync_fifo #(
   parameter  int WIDTH = 2,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Reads are gated while empty so the unreset storage never reaches the port.
   assign dout = empty ? '0 : mem[rptr];

   // NOTE: the storage array has no reset; only pointers and count need one, and
   // leaving it out keeps the array mappable to plain flops/LUT-RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/btn_event_queue.sv
// Captures debounced press pulses, serialises them lowest-index-first and queues
// button IDs for the control FSM over a valid/ready handshake.
module btn_event_queue
   import btn_pkg::*;
#(
   parameter  int NUM_BTN = NUM_BTN_DEF,
   parameter  int DEPTH   = DEPTH_DEF,
   localparam int ID_W    = $clog2(NUM_BTN),
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_BTN-1:0] btn_pulse,
   output logic               evt_valid,
   output logic [ID_W-1:0]    evt_id,
   input  logic               evt_ready,
   output logic [CNT_W-1:0]   evt_count,
   output logic               overflow,
   input  logic               clr_overflow
);

   logic [NUM_BTN-1:0] pending;
   logic [NUM_BTN-1:0] sel_onehot;
   logic [NUM_BTN-1:0] push_clr;
   logic [ID_W-1:0]    sel_id;
   logic               found;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic               drop;

   // NOTE: every output of this block is defaulted before the loop, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      sel_id     = '0;
      sel_onehot = '0;
      found      = 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (pending[i] && !found) begin
            sel_id        = ID_W'(i);
            sel_onehot[i] = 1'b1;
            found         = 1'b1;
         end
      end
   end

   assign evt_valid = !empty;
   assign pop       = evt_valid && evt_ready;
   assign push      = (|pending) && (!full || pop);
   assign push_clr  = push ? sel_onehot : '0;

   // A press is lost only when its button is already waiting and not leaving now.
   assign drop = |(btn_pulse & pending & ~push_clr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         pending <= (pending & ~push_clr) | btn_pulse;
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (ID_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     (sel_id),
      .pop     (pop),
      .dout    (evt_id),
      .full    (full),
      .empty   (empty),
      .count   (evt_count)
   );

endmodule

// File: tb/tb_btn_event_queue.sv
// Directed bench for btn_event_queue: expected IDs go into a scoreboard queue,
// a monitor checks every handshake; level checks cover count/overflow/reset.
module tb_btn_event_queue;
   import btn_pkg::*;

   localparam int NB    = 4;
   localparam int DEPTH = 8;
   localparam int ID_W  = $clog2(NB);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NB-1:0]    btn_pulse;
   logic             evt_valid;
   logic [ID_W-1:0]  evt_id;
   logic             evt_ready;
   logic [CNT_W-1:0] evt_count;
   logic             overflow;
   logic             clr_overflow;

   int n_checks = 0;
   int n_errors = 0;
   int exp_q[$];

   btn_event_queue #(.NUM_BTN(NB), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .btn_pulse    (btn_pulse),
      .evt_valid    (evt_valid),
      .evt_id       (evt_id),
      .evt_ready    (evt_ready),
      .evt_count    (evt_count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every accepted event must match the oldest expected ID.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_event", int'(evt_id), -1);
            end else begin
               check("event_id", int'(evt_id), exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [NB-1:0] mask);
      btn_pulse = mask;
      step();
      btn_pulse = '0;
   endtask

   task automatic drain(input string name);
      bit ok;
      ok = 1'b0;
      evt_ready = 1'b1;
      for (int c = 0; c < 200; c++) begin
         step();
         if (!evt_valid && dut.pending == '0) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_drain_done"}, int'(ok), 1);
      check({name, "_scoreboard_empty"}, exp_q.size(), 0);
      check({name, "_count_zero"}, int'(evt_count), 0);
      evt_ready = 1'b0;
   endtask

   initial begin
      reset_n      = 1'b0;
      btn_pulse    = '0;
      evt_ready    = 1'b0;
      clr_overflow = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", int'(evt_valid), 0);
      check("rst_id", int'(evt_id), 0);
      check("rst_count", int'(evt_count), 0);
      check("rst_overflow", int'(overflow), 0);
      step();
      reset_n = 1'b1;
      step();

      // Single press: visible exactly two cycles after the pulse cycle.
      evt_ready = 1'b1;
      exp_q.push_back(BTN_LEFT);
      btn_pulse = 4'b0100;
      @(negedge clk);
      check("single_c0_valid", int'(evt_valid), 0);
      step();
      btn_pulse = '0;
      @(negedge clk);
      check("single_c1_valid", int'(evt_valid), 0);
      step();
      @(negedge clk);
      check("single_c2_valid", int'(evt_valid), 1);
      check("single_c2_id", int'(evt_id), BTN_LEFT);
      step();
      @(negedge clk);
      check("single_c3_valid", int'(evt_valid), 0);
      check("single_count", int'(evt_count), 0);
      check("single_overflow", int'(overflow), 0);
      step();

      // Simultaneous press: queued lowest index first.
      evt_ready = 1'b0;
      exp_q.push_back(BTN_UP);
      exp_q.push_back(BTN_DOWN);
      exp_q.push_back(BTN_RIGHT);
      pulse(4'b1011);
      repeat (4) step();
      check("simul_count", int'(evt_count), 3);
      evt_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("simul_back_to_back_valid", int'(evt_valid), 1);
         step();
      end
      @(negedge clk);
      check("simul_drained", int'(evt_count), 0);
      step();

      // Fill and backpressure: 10 alternating presses, 8 stored, 2 waiting.
      evt_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         exp_q.push_back(k % 2);
         pulse((k % 2 == 0) ? 4'b0001 : 4'b0010);
         repeat (2) step();
      end
      repeat (2) step();
      check("fill_count", int'(evt_count), 8);
      check("fill_pending", int'(dut.pending), 4'b0011);
      check("fill_overflow", int'(overflow), 0);
      drain("fill");

      // Repeat drop while full: second press of button 2 is lost, overflow sticks.
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(BTN_RIGHT);
         pulse(4'b1000);
         repeat (2) step();
      end
      check("drop_full_count", int'(evt_count), 8);
      exp_q.push_back(BTN_LEFT);
      pulse(4'b0100);
      check("drop_first_no_ovf", int'(overflow), 0);
      repeat (4) step();
      pulse(4'b0100);
      check("drop_second_ovf", int'(overflow), 1);
      repeat (3) step();
      check("drop_ovf_sticky", int'(overflow), 1);
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      check("drop_ovf_cleared", int'(overflow), 0);
      drain("drop");

      // Push and pop at full across pointer wrap: 8 + 3x4 = 20 events.
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(k % 4);
         pulse(4'(1 << (k % 4)));
         repeat (2) step();
      end
      for (int r = 0; r < 3; r++) begin
         for (int b = 0; b < 4; b++) exp_q.push_back(b);
         evt_ready = 1'b0;
         pulse(4'b1111);
         evt_ready = 1'b1;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("full_pushpop_count", int'(evt_count), 8);
            step();
         end
         evt_ready = 1'b0;
      end
      drain("wrap");

      // Asynchronous reset mid-operation with 5 queued and button 0 waiting.
      for (int k = 0; k < 5; k++) begin
         pulse(4'b0010);
         repeat (2) step();
      end
      check("areset_pre_count", int'(evt_count), 5);
      exp_q.push_back(BTN_UP);
      pulse(4'b0001);
      exp_q.pop_back();
      #2;
      reset_n = 1'b0;
      #1;
      check("areset_valid", int'(evt_valid), 0);
      check("areset_count", int'(evt_count), 0);
      check("areset_overflow", int'(overflow), 0);
      exp_q.delete();
      step();
      reset_n   = 1'b1;
      evt_ready = 1'b1;
      repeat (10) step();
      check("post_reset_valid", int'(evt_valid), 0);
      check("post_reset_count", int'(evt_count), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
